// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multi-cycle data/instruction memory responder with stall/done/err handshake
//
// Purpose:
//   Responder side of the processor memory request interface. Accepts one read
//   or write at a time, holds stall while the request is outstanding, and
//   completes with a one-cycle done pulse LATENCY cycles after acceptance.
//   Illegal requests (rd and wr together, or an odd byte address) complete
//   with err=1 and data_out=0 and do not touch the array.
//
// Parameters:
//   AW       word-address width; the array holds 2^AW 16-bit words (AW <= 14)
//   LATENCY  cycles from acceptance to the done cycle, 1..15
//
// Optional feature:
//   MEM_RESPONDER_READ_HIT_EN  one-entry last-read buffer; a legal read that
//                              hits it completes in the cycle after acceptance
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-low reset
//   addr_i      byte address of request
//   data_in_i   write data
//   rd_i        read request
//   wr_i        write request
//   data_out_o  read data, valid while done_o=1
//   stall_o     requester must hold its request and freeze its pipeline
//   done_o      one-cycle completion pulse
//   err_o       illegal request indicator, valid while done_o=1

module mem_responder #(
  parameter int AW      = 13,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_in_i,
  input  logic        rd_i,
  input  logic        wr_i,
  output logic [15:0] data_out_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int         DEPTH    = 1 << AW;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [15:0]   wdata_q;
  logic          rd_q;
  logic          wr_q;
  logic          ill_q;
  logic [15:0]   data_out_q;
  logic          done_q;
  logic          err_q;

  logic [15:0]   mem_q [DEPTH];

  logic          req;
  logic          accept;
  logic          ill_in;
  logic [AW-1:0] idx_in;
  logic          fast;
  logic          commit;
  logic          c_rd;
  logic          c_wr;
  logic          c_ill;
  logic [AW-1:0] c_idx;
  logic [15:0]   c_wdata;
  logic          mem_we;
  logic [15:0]   mem_rdata;
  logic [15:0]   cmp_dout;
  logic          hit;
  logic [15:0]   hit_data;

  // Address bits above the word index alias onto the array.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^addr_i[15:AW+1];

  assign req    = rd_i | wr_i;
  assign accept = (state_q != S_BUSY) && req;
  assign ill_in = (rd_i & wr_i) | addr_i[0];
  assign idx_in = addr_i[AW:1];

  // With LATENCY=1 the access happens on the acceptance edge itself, so the
  // completion datapath takes the live inputs instead of the latched copy.
  assign fast   = accept && (LATENCY == 1);
  assign commit = ((state_q == S_BUSY) && (cnt_q == 4'd1)) || fast;

  assign c_rd    = fast ? rd_i      : rd_q;
  assign c_wr    = fast ? wr_i      : wr_q;
  assign c_ill   = fast ? ill_in    : ill_q;
  assign c_idx   = fast ? idx_in    : idx_q;
  assign c_wdata = fast ? data_in_i : wdata_q;

  // Gating with rst_i keeps a LATENCY=1 write from landing while in reset.
  assign mem_we    = commit && c_wr && !c_ill && rst_i;
  assign mem_rdata = mem_q[c_idx];

  // Writes leave data_out at its previous value; illegal requests force zero.
  assign cmp_dout = c_ill ? 16'h0000 : (c_rd ? mem_rdata : data_out_q);

`ifdef MEM_RESPONDER_READ_HIT_EN
  logic          hb_valid_q;
  logic [AW-1:0] hb_idx_q;
  logic [15:0]   hb_data_q;

  assign hit      = accept && rd_i && !wr_i && !addr_i[0] &&
                    hb_valid_q && (hb_idx_q == idx_in);
  assign hit_data = hb_data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hb_valid_q <= 1'b0;
      hb_idx_q   <= '0;
      hb_data_q  <= 16'h0000;
    end else if (commit && c_rd && !c_ill) begin
      hb_valid_q <= 1'b1;
      hb_idx_q   <= c_idx;
      hb_data_q  <= mem_rdata;
    end else if (accept && wr_i && (hb_idx_q == idx_in)) begin
      hb_valid_q <= 1'b0;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 16'h0000;
`endif

  // Array has no reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 16'h0000;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ill_q      <= 1'b0;
      data_out_q <= 16'h0000;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_BUSY: begin
          // Requester inputs are ignored here.
          cnt_q <= cnt_q - 4'd1;
          if (commit) begin
            state_q    <= S_DONE;
            data_out_q <= cmp_dout;
            done_q     <= 1'b1;
            err_q      <= c_ill;
          end
        end
        default: begin
          // IDLE and DONE both accept; a request in DONE is back-to-back.
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (accept) begin
            idx_q   <= idx_in;
            wdata_q <= data_in_i;
            rd_q    <= rd_i;
            wr_q    <= wr_i;
            ill_q   <= ill_in;
            cnt_q   <= CNT_INIT;
            if (hit) begin
              state_q    <= S_DONE;
              data_out_q <= hit_data;
              done_q     <= 1'b1;
            end else if (fast) begin
              state_q    <= S_DONE;
              data_out_q <= cmp_dout;
              done_q     <= 1'b1;
              err_q      <= c_ill;
            end else begin
              state_q <= S_BUSY;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign stall_o    = (state_q == S_BUSY) || req;
  assign data_out_o = data_out_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard testbench for mem_responder

module tb_mem_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] din;
  logic        rd;
  logic        wr;
  logic [15:0] dout;
  logic        stall;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic        chk;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] model [int];

`ifdef MEM_RESPONDER_READ_HIT_EN
  bit          hb_v = 1'b0;
  int          hb_w = 0;
`endif

  mem_responder #(.AW(13), .LATENCY(LAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .addr_i     (addr),
    .data_in_i  (din),
    .rd_i       (rd),
    .wr_i       (wr),
    .data_out_o (dout),
    .stall_o    (stall),
    .done_o     (done),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  // Drive a request and push the expected completion to the scoreboard.
  task automatic txn(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    int   wd;
    bit   ill;
    wd    = int'(a[13:1]);
    ill   = (r & w) | a[0];
    e.lat = LAT;
    e.chk = 1'b1;
    e.err = ill;
    e.data = 16'h0000;
`ifdef MEM_RESPONDER_READ_HIT_EN
    if (w && hb_w == wd) hb_v = 1'b0;
`endif
    if (!ill) begin
      if (w) begin
        model[wd] = d;
        e.chk     = 1'b0;
      end else begin
        e.data = model.exists(wd) ? model[wd] : 16'h0000;
`ifdef MEM_RESPONDER_READ_HIT_EN
        if (hb_v && hb_w == wd) e.lat = 1;
        hb_v = 1'b1;
        hb_w = wd;
`endif
      end
    end
    sb.push_back(e);
    rd   = r;
    wr   = w;
    addr = a;
    din  = d;
  endtask

  // From the presentation negedge: accept at next posedge, drop the request,
  // count sampled cycles until done (bounded). Ends on the done negedge.
  task automatic wait_done(output int n, output bit sok);
    n   = 0;
    sok = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
    while (n < 64) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (!stall) sok = 1'b0;
    end
  endtask

  task automatic run(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                     output int n, output bit sok, output bit st0, output exp_t e);
    txn(r, w, a, d);
    #1;
    st0 = stall;
    wait_done(n, sok);
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = 16'h0000; din = 16'h0000;
    #12;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL rst_dout got=%h exp=0000", dout); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Table-driven sequence; gap=1 inserts an idle cycle before the request.
  task automatic test_seq(input string nm, input int cnt, input bit gap [8], input bit tr [8],
                          input bit tw [8], input logic [15:0] ta [8], input logic [15:0] td [8]);
    int   n;
    bit   sok;
    bit   st0;
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      if (gap[i]) @(negedge clk);
      run(tr[i], tw[i], ta[i], td[i], n, sok, st0, e);
      checks++; if (n !== e.lat) begin errors++; $display("FAIL %s[%0d] latency got=%0d exp=%0d", nm, i, n, e.lat); end
      checks++; if (err !== e.err) begin errors++; $display("FAIL %s[%0d] err got=%b exp=%b", nm, i, err, e.err); end
      if (e.chk) begin
        checks++; if (dout !== e.data) begin errors++; $display("FAIL %s[%0d] data got=%h exp=%h", nm, i, dout, e.data); end
      end
      checks++; if (st0 !== 1'b1) begin errors++; $display("FAIL %s[%0d] stall_on_req got=%b exp=1", nm, i, st0); end
      checks++; if (sok !== 1'b1) begin errors++; $display("FAIL %s[%0d] stall_busy got=%b exp=1", nm, i, sok); end
    end
  endtask

  task automatic test_write_read();
    bit          g [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    bit          r [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    bit          w [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] a [8] = '{16'h0010, 16'h0010, 0, 0, 0, 0, 0, 0};
    logic [15:0] d [8] = '{16'hBEEF, 16'h0000, 0, 0, 0, 0, 0, 0};
    test_seq("write_read", 2, g, r, w, a, d);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall got=%b exp=0", stall); end
  endtask

  task automatic test_back_to_back();
    bit          g [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    bit          r [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    bit          w [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] a [8] = '{16'h0010, 16'h0010, 0, 0, 0, 0, 0, 0};
    logic [15:0] d [8] = '{16'hBEEF, 16'h0000, 0, 0, 0, 0, 0, 0};
    test_seq("back_to_back", 2, g, r, w, a, d);
  endtask

  task automatic test_illegal();
    bit          g [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    bit          r [8] = '{0, 1, 1, 1, 0, 0, 0, 0};
    bit          w [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    logic [15:0] a [8] = '{16'h0020, 16'h0020, 16'h0011, 16'h0020, 0, 0, 0, 0};
    logic [15:0] d [8] = '{16'h2020, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 0, 0};
    test_seq("illegal", 4, g, r, w, a, d);
  endtask

  task automatic test_reset_midop();
    bit          g [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    bit          r [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    bit          w [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] a [8] = '{16'h0030, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] d [8] = '{16'hA5A5, 0, 0, 0, 0, 0, 0, 0};
    bit          seen;
    test_seq("midop_pre", 1, g, r, w, a, d);
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; addr = 16'h0030; din = 16'h1234;
    @(posedge clk);
    #1;
    wr = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
`ifdef MEM_RESPONDER_READ_HIT_EN
    hb_v = 1'b0;
`endif
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midop_idle_stall got=%b exp=0", stall); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL midop_dout got=%h exp=0000", dout); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midop_no_done got=%b exp=0", seen); end
    r[0] = 1'b1; w[0] = 1'b0; d[0] = 16'h0000;
    test_seq("midop_read", 1, g, r, w, a, d);
  endtask

  task automatic test_read_hit();
    bit          g [8] = '{1, 1, 0, 1, 1, 0, 0, 0};
    bit          r [8] = '{0, 1, 1, 0, 1, 0, 0, 0};
    bit          w [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
    logic [15:0] a [8] = '{16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0040, 0, 0, 0};
    logic [15:0] d [8] = '{16'h4040, 16'h0000, 16'h0000, 16'h5555, 16'h0000, 0, 0, 0};
    test_seq("read_hit", 5, g, r, w, a, d);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_illegal();
    test_reset_midop();
    test_read_hit();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
